// File: rtl/fifo_wr_arbiter_if.sv
// Signal bundle between the N requesters, the arbiter and the downstream FIFO write port.
// The arbiter takes the slave modport; whatever drives the requesters and the FIFO full flag takes master.
interface fifo_wr_arbiter_if #(
    parameter int N  = 4,
    parameter int DW = 16
);
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_wdata;
    logic [N-1:0]    grant;
    logic            busy;

    modport master (
        output req, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wdata, grant, busy
    );

    modport slave (
        input  req, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_wdata, grant, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port between N requesters.
// Optional FIFO_ARB_MAXBURST_EN: also release the grant after MAX_BURST accepted beats.
module fifo_wr_arbiter #(
    parameter int N         = 4,
    parameter int DW        = 16,
    parameter int MAX_BURST = 16
) (
    input  logic             clk,
    input  logic             rest_n,
    fifo_wr_arbiter_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic [N-1:0]  r_grant, w_grant_nxt;
    logic [PW-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [PW-1:0] w_scan, w_pick, w_gidx;
    logic          w_found, w_g_req, w_g_last, w_busy, w_accept, w_cap_hit, w_release;
    logic [DW-1:0] w_g_data;

    if (MAX_BURST < 1) begin : g_bad_cfg
        $error("fifo_wr_arbiter: MAX_BURST must be >= 1");
    end

    // Cyclic scan starting at the round-robin pointer; first requester found wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_scan  = '0;
        for (int k = 0; k < N; k++) begin
            w_scan = PW'((int'(r_rr_ptr) + k) % N);
            if (!w_found && bus.req[w_scan]) begin
                w_found = 1'b1;
                w_pick  = w_scan;
            end
        end
    end

    always_comb begin
        w_g_req  = 1'b0;
        w_g_last = 1'b0;
        w_g_data = '0;
        w_gidx   = '0;
        for (int i = 0; i < N; i++) begin
            if (r_grant[i]) begin
                w_g_req  = bus.req[i];
                w_g_last = bus.req_last[i];
                w_g_data = bus.req_data[i*DW +: DW];
                w_gidx   = PW'(i);
            end
        end
    end

    assign w_busy    = (r_state == BURST);
    assign w_accept  = w_busy & w_g_req & ~bus.fifo_full;
    assign w_release = w_accept & (w_g_last | w_cap_hit);

`ifdef FIFO_ARB_MAXBURST_EN
    localparam int CW = $clog2(MAX_BURST) + 1;

    logic [CW-1:0] r_beat_cnt;

    assign w_cap_hit = ((r_beat_cnt + 1'b1) == CW'(MAX_BURST));

    // Counts beats of the current grant only; cleared whenever no grant is active.
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            r_beat_cnt <= '0;
        end else if (!w_busy || w_release) begin
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
        end
    end
`else
    assign w_cap_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = BURST;
                    w_grant_nxt = N'(1) << w_pick;
                end
            end
            BURST: begin
                if (w_release) begin
                    w_state_nxt  = IDLE;
                    w_grant_nxt  = '0;
                    w_rr_ptr_nxt = (w_gidx == PW'(N - 1)) ? '0 : w_gidx + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    assign bus.busy       = w_busy;
    assign bus.grant      = r_grant;
    assign bus.req_ready  = (w_busy && !bus.fifo_full) ? r_grant : '0;
    assign bus.fifo_wr_en = w_accept;
    assign bus.fifo_wdata = w_busy ? w_g_data : '0;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: constant vector table, directed corner sequences,
// and random traffic checked against a packet-level reference model.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 4;
`ifdef FIFO_ARB_MAXBURST_EN
    localparam bit MB_EN = 1'b1;
`else
    localparam bit MB_EN = 1'b0;
`endif

    logic clk    = 1'b0;
    logic rest_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N(N), .DW(DW)) bus ();

    fifo_wr_arbiter #(.N(N), .DW(DW), .MAX_BURST(MB)) dut (
        .clk    (clk),
        .rest_n (rest_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;

    // Reference model state: owner index (-1 = nobody), next-priority index, beats this grant.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_acc   = -1;

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  last;
        logic          full;
        logic [DW-1:0] d;
        logic [N-1:0]  g;
        logic [N-1:0]  rdy;
        logic          wr;
        logic [DW-1:0] wd;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(input logic [N-1:0] req, input logic [N-1:0] last, input logic full,
                                input logic [DW-1:0] d, input logic [N-1:0] g, input logic [N-1:0] rdy,
                                input logic wr, input logic [DW-1:0] wd);
        vec_t v;
        v.req = req; v.last = last; v.full = full; v.d = d;
        v.g = g; v.rdy = rdy; v.wr = wr; v.wd = wd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic lane(input int i, input logic r, input logic l, input logic [DW-1:0] d);
        bus.req[i]               = r;
        bus.req_last[i]          = l;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_acc   = -1;
    endtask

    task automatic do_reset();
        rest_n        = 1'b0;
        bus.req       = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst.grant", bus.grant, 0);
        chk("rst.busy", bus.busy, 0);
        chk("rst.wr_en", bus.fifo_wr_en, 0);
        chk("rst.ready", bus.req_ready, 0);
        chk("rst.wdata", bus.fifo_wdata, 0);
        @(negedge clk);
        rest_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    // Called at posedge+1 with inputs already applied; checks this cycle, advances model to next edge.
    task automatic cycle_check(input string nm);
        logic [N-1:0]  eg, er;
        logic          ew;
        logic [DW-1:0] ed;
        bit            hit;
        #2;
        eg = '0; er = '0; ew = 1'b0; ed = '0; m_acc = -1;
        if (m_owner >= 0) begin
            eg = N'(1) << m_owner;
            ed = DW'(bus.req_data >> (m_owner * DW));
            if (!bus.fifo_full) er = eg;
            if (bus.req[m_owner] && !bus.fifo_full) begin
                ew    = 1'b1;
                m_acc = m_owner;
            end
        end
        chk({nm, ".grant"}, bus.grant, eg);
        chk({nm, ".busy"}, bus.busy, (m_owner >= 0));
        chk({nm, ".ready"}, bus.req_ready, er);
        chk({nm, ".wr_en"}, bus.fifo_wr_en, ew);
        chk({nm, ".wdata"}, bus.fifo_wdata, ed);
        if (bus.fifo_wr_en === 1'b1) n_wr++;
        if (m_owner < 0) begin
            hit = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!hit && bus.req[(m_ptr + k) % N]) begin
                    hit     = 1'b1;
                    m_owner = (m_ptr + k) % N;
                    m_cnt   = 0;
                end
            end
        end else if (m_acc >= 0) begin
            m_cnt++;
            if (bus.req_last[m_owner] || (MB_EN && m_cnt == MB)) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    int rem[N];
    int seq[N];
    int wr0;

    initial begin
        // Round robin from reset, then single requester 2, then a full stall on requester 1.
        tbl[0]  = mk(4'hF, 4'hF, 0, 16'h0010, 4'h0, 4'h0, 0, 16'h0000);
        tbl[1]  = mk(4'hF, 4'hF, 0, 16'h0011, 4'h1, 4'h1, 1, 16'h0011);
        tbl[2]  = mk(4'hF, 4'hF, 0, 16'h0012, 4'h0, 4'h0, 0, 16'h0000);
        tbl[3]  = mk(4'hF, 4'hF, 0, 16'h0013, 4'h2, 4'h2, 1, 16'h0013);
        tbl[4]  = mk(4'hF, 4'hF, 0, 16'h0014, 4'h0, 4'h0, 0, 16'h0000);
        tbl[5]  = mk(4'hF, 4'hF, 0, 16'h0015, 4'h4, 4'h4, 1, 16'h0015);
        tbl[6]  = mk(4'hF, 4'hF, 0, 16'h0016, 4'h0, 4'h0, 0, 16'h0000);
        tbl[7]  = mk(4'hF, 4'hF, 0, 16'h0017, 4'h8, 4'h8, 1, 16'h0017);
        tbl[8]  = mk(4'hF, 4'hF, 0, 16'h0018, 4'h0, 4'h0, 0, 16'h0000);
        tbl[9]  = mk(4'hF, 4'hF, 0, 16'h0019, 4'h1, 4'h1, 1, 16'h0019);
        tbl[10] = mk(4'h0, 4'h0, 0, 16'h0000, 4'h0, 4'h0, 0, 16'h0000);
        tbl[11] = mk(4'h4, 4'h0, 0, 16'h00A0, 4'h0, 4'h0, 0, 16'h0000);
        tbl[12] = mk(4'h4, 4'h0, 0, 16'h00A0, 4'h4, 4'h4, 1, 16'h00A0);
        tbl[13] = mk(4'h4, 4'h0, 0, 16'h00A1, 4'h4, 4'h4, 1, 16'h00A1);
        tbl[14] = mk(4'h4, 4'h0, 0, 16'h00A2, 4'h4, 4'h4, 1, 16'h00A2);
        tbl[15] = mk(4'h4, 4'h4, 0, 16'h00A3, 4'h4, 4'h4, 1, 16'h00A3);
        tbl[16] = mk(4'h0, 4'h0, 0, 16'h0000, 4'h0, 4'h0, 0, 16'h0000);
        tbl[17] = mk(4'h2, 4'h2, 1, 16'h00B0, 4'h0, 4'h0, 0, 16'h0000);
        tbl[18] = mk(4'h2, 4'h2, 1, 16'h00B0, 4'h2, 4'h0, 0, 16'h00B0);
        tbl[19] = mk(4'h2, 4'h2, 0, 16'h00B0, 4'h2, 4'h2, 1, 16'h00B0);
        tbl[20] = mk(4'h0, 4'h0, 0, 16'h0000, 4'h0, 4'h0, 0, 16'h0000);

        do_reset();
        for (int k = 0; k < 21; k++) begin
            bus.req       = tbl[k].req;
            bus.req_last  = tbl[k].last;
            bus.fifo_full = tbl[k].full;
            bus.req_data  = {N{tbl[k].d}};
            #2;
            chk($sformatf("vec%0d.grant", k), bus.grant, tbl[k].g);
            chk($sformatf("vec%0d.ready", k), bus.req_ready, tbl[k].rdy);
            chk($sformatf("vec%0d.wr_en", k), bus.fifo_wr_en, tbl[k].wr);
            chk($sformatf("vec%0d.wdata", k), bus.fifo_wdata, tbl[k].wd);
            chk($sformatf("vec%0d.busy", k), bus.busy, (tbl[k].g != 0));
            @(posedge clk);
            #1;
        end

        // Backpressure: 3-beat packet on requester 1, FIFO full for 5 clks after the first beat.
        do_reset();
        wr0 = n_wr;
        lane(1, 1'b1, 1'b0, 16'h00C0);
        cycle_check("bp.arb");
        cycle_check("bp.b0");
        lane(1, 1'b1, 1'b0, 16'h00C1);
        bus.fifo_full = 1'b1;
        repeat (5) cycle_check("bp.full");
        bus.fifo_full = 1'b0;
        cycle_check("bp.b1");
        lane(1, 1'b1, 1'b1, 16'h00C2);
        cycle_check("bp.b2");
        lane(1, 1'b0, 1'b0, 16'h0000);
        cycle_check("bp.rel");
        chk("bp.writes", n_wr - wr0, 3);

        // Owner stalls mid-packet while requester 3 waits.
        do_reset();
        lane(0, 1'b1, 1'b0, 16'h00D0);
        lane(3, 1'b1, 1'b1, 16'h00E0);
        cycle_check("stall.arb");
        cycle_check("stall.b0");
        lane(0, 1'b0, 1'b0, 16'h00D1);
        repeat (3) cycle_check("stall.gap");
        lane(0, 1'b1, 1'b1, 16'h00D1);
        cycle_check("stall.b1");
        lane(0, 1'b0, 1'b0, 16'h0000);
        cycle_check("stall.arb3");
        cycle_check("stall.e0");
        chk("stall.grant_after", bus.grant, 0);
        lane(3, 1'b0, 1'b0, 16'h0000);
        cycle_check("stall.idle");

`ifdef FIFO_ARB_MAXBURST_EN
        // Requester 0 streams without last; cap forces hand-over to requester 1 and back.
        do_reset();
        seq[0] = 0;
        lane(0, 1'b1, 1'b0, 16'h0F00);
        lane(1, 1'b1, 1'b1, 16'h0100);
        for (int c = 0; c < 20; c++) begin
            cycle_check("mb");
            if (m_acc == 0) begin
                seq[0]++;
                lane(0, 1'b1, 1'b0, 16'h0F00 + DW'(seq[0]));
            end
            if (m_acc == 1) lane(1, 1'b0, 1'b0, 16'h0000);
        end
`endif

        // Asynchronous reset in the middle of a burst clears the grant without a clock edge.
        do_reset();
        lane(2, 1'b1, 1'b0, 16'h0077);
        cycle_check("ar.arb");
        cycle_check("ar.b0");
        #2;
        rest_n = 1'b0;
        #1;
        chk("ar.grant", bus.grant, 0);
        chk("ar.busy", bus.busy, 0);
        chk("ar.wr_en", bus.fifo_wr_en, 0);
        chk("ar.ready", bus.req_ready, 0);
        chk("ar.wdata", bus.fifo_wdata, 0);
        do_reset();

        // Random traffic: random packet lengths, random req gaps, random FIFO full.
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) rem[i] = int'($urandom_range(1, 5));
                lane(i, ($urandom % 4) != 0, rem[i] == 1, {i[3:0], seq[i][11:0]});
            end
            bus.fifo_full = ($urandom % 4) == 0;
            cycle_check("rnd");
            if (m_acc >= 0) begin
                seq[m_acc]++;
                rem[m_acc]--;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares one FIFO write port between N requesters, e.g. several PE output lanes feeding a single line buffer.
- Sits in the FIFO write-clock domain, in front of the FIFO write port.
- Consumes the FIFO's `full` flag.
- Drives the FIFO's write enable and write data.
- A grant is held until the owning requester delivers its last beat, so packets are never interleaved.

Parameters:
- N, 4, number of requesters; any value ≥ 1.
- DW, 16, data width per requester.
- MAX_BURST, 16, beat cap per grant; used only when FIFO_ARB_MAXBURST_EN is defined.

Ports:
- clk  in  1  write-domain clock; drives all state.
- rest_n  in  1  asynchronous active-low reset.
- req  in  N  per-requester valid; bit i means requester i has a beat on its data slice.
- req_data  in  N*DW  packed data; slice i is bits [i*DW +: DW].
- req_last  in  N  bit i marks the final beat of requester i's packet.
- req_ready  out  N  bit i high means a beat from requester i is accepted this cycle if req[i]=1.
- fifo_full  in  1  full flag of the downstream FIFO, same clock.
- fifo_wr_en  out  1  FIFO write strobe.
- fifo_wdata  out  DW  FIFO write data.
- grant  out  N  one-hot registered owner of the write port; all zero when idle.
- busy  out  1  high while in state BURST.

Behaviour:
- Reset (rest_n=0, async) sets: state IDLE, grant=0, rr_ptr=0, beat_cnt=0. Outputs during reset: busy=0, req_ready=0, fifo_wr_en=0, fifo_wdata=0.
- State IDLE:
  - If any req bit is set, select the first index i with req[i]=1, scanning cyclically from rr_ptr: rr_ptr, rr_ptr+1, …, N-1, 0, ….
  - Register grant=onehot(i) and move to BURST.
  - No beat is accepted in IDLE; req_ready=0.
  - Grant latency is 1 clk from req assertion.
- State BURST, with g = index of the granted requester:
  - req_ready[g] = ~fifo_full; all other req_ready bits are 0. Combinational.
  - Accept condition: req[g] & ~fifo_full.
  - fifo_wr_en = accept, combinational.
  - fifo_wdata = req_data slice g while in BURST; 0 in IDLE.
  - Accepted beat with req_last[g]=1: next cycle grant=0, state IDLE, rr_ptr = (g+1) wraps to 0 when g=N-1.
  - Granted requester deasserts req mid-packet: grant is held, no writes, no timeout.
  - fifo_full=1: no write and no ready; the grant is held; data is not lost because the requester holds its beat.
  - Non-granted req bits are ignored until the grant returns to IDLE.
- Throughput:
  - 1 beat/clk within a packet.
  - One idle bubble cycle between packets (release cycle, then arbitration cycle).
  - A single-beat packet therefore occupies 2 clks.
- Fairness: a requester that just finished gets lowest priority next round. With all N requesting, grants rotate 0,1,…,N-1,0.
- N=1: rr_ptr stays 0; behaves as a plain pass-through with the bubble.
- req_last on a non-accepted cycle has no effect.
- Width rules:
  - rr_ptr width = max(1, $clog2(N)).
  - beat_cnt width = $clog2(MAX_BURST)+1.
  - beat_cnt resets to 0 on every grant.

Optional Feature:
- FIFO_ARB_MAXBURST_EN
- Defined:
  - beat_cnt increments on each accept.
  - When an accepted beat brings beat_cnt to MAX_BURST, the grant is released exactly as if req_last were set: state IDLE, rr_ptr=g+1.
  - The requester resumes its packet on a later grant; req_last semantics are unchanged.
  - This bounds the wait of any other requester to MAX_BURST+2 clks per competitor.
- Undefined: no beat counter logic; grants are released only on req_last.

Test Plan:
- Reset then idle:
  - Stimulus: rest_n low 3 clks, all req=0.
  - Response: grant=0, busy=0, fifo_wr_en=0, req_ready=0; asserting rest_n low mid-BURST clears grant immediately, with no clock.
- Single requester:
  - Stimulus: req[2]=1 with 4 beats 0xA0..0xA3, last on 0xA3, fifo_full=0.
  - Response: grant=0b0100 one clk after req; fifo_wr_en high 4 consecutive clks with fifo_wdata A0,A1,A2,A3; grant=0 the clk after.
- Round-robin:
  - Stimulus: N=4, all req held high, 1-beat packets (last=1).
  - Response: grant sequence 0001,0010,0100,1000,0001; one write every 2 clks.
- Backpressure:
  - Stimulus: during a 3-beat packet from requester 1, fifo_full=1 for 5 clks after beat 1.
  - Response: fifo_wr_en=0 and req_ready=0 for those 5 clks; grant stays 0b0010; beats 2–3 written after full drops; no duplicate or lost beat.
- Stall by owner:
  - Stimulus: requester 0 granted, drops req for 3 clks mid-packet while req[3]=1.
  - Response: grant stays 0b0001, no writes; requester 3 granted only after requester 0's last beat.
- With FIFO_ARB_MAXBURST_EN, MAX_BURST=4:
  - Stimulus: requester 0 streams 10 beats without last; req[1]=1.
  - Response: after beat 4, grant moves to 0b0010; requester 0 regains the grant after requester 1's packet.
